// File: rtl/hamming_frame_decoder.sv
// Hamming(7,4) receive decoder: corrects single-bit errors, gathers six nibbles
// into a frame, and replays each frame as a gapless 6-cycle burst.
module hamming_frame_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       code_in,
  input  logic             code_valid,
  input  logic             frame_start,
  output logic [3:0]       out,
  output logic             enable,
  output logic             busy,
  output logic             corrected,
  output logic             sync_err,
  output logic [CNT_W-1:0] err_count
);
  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         widx_q, widx_d;
  logic [2:0]         ridx_q, ridx_d;
  logic [5:0][3:0]    slot_q, slot_d;
  logic [5:0][3:0]    outbuf_q, outbuf_d;
  logic [3:0]         out_q, out_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               corrected_q, corrected_d;
  logic               sync_err_q, sync_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [2:0]         syn;
  logic [6:0]         fixed;
  logic [3:0]         nib;
  logic [3:0]         rd_nib;
  logic               done;

  always_comb begin
    syn[0] = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6];
    syn[1] = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6];
    syn[2] = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];
    fixed  = code_in;
    for (int i = 0; i < 7; i++)
      if (syn == 3'(i + 1)) fixed[i] = ~code_in[i];
    nib = {fixed[2], fixed[4], fixed[5], fixed[6]};
  end

  // Assembly buffer, error counter and per-codeword status pulses.
  always_comb begin
    widx_d      = widx_q;
    slot_d      = slot_q;
    outbuf_d    = outbuf_q;
    cnt_d       = cnt_q;
    corrected_d = 1'b0;
    sync_err_d  = 1'b0;
    done        = 1'b0;
    if (code_valid) begin
      corrected_d = |syn;
      if (|syn && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
      if (frame_start) begin
        sync_err_d = (widx_q != 3'd0);
        slot_d[0]  = nib;
        widx_d     = 3'd1;
      end else begin
        for (int i = 0; i < 6; i++)
          if (widx_q == 3'(i)) slot_d[i] = nib;
        if (widx_q == 3'd5) begin
          widx_d = 3'd0;
          done   = 1'b1;
        end else begin
          widx_d = widx_q + 3'd1;
        end
      end
    end
    if (done) outbuf_d = slot_d;
  end

  // Burst FSM; a completing frame always (re)starts at nibble 0.
  always_comb begin
    state_d  = state_q;
    ridx_d   = ridx_q;
    out_d    = out_q;
    enable_d = 1'b0;
    busy_d   = 1'b0;
    rd_nib   = outbuf_q[0];
    for (int i = 0; i < 6; i++)
      if (ridx_q == 3'(i)) rd_nib = outbuf_q[i];
    case (state_q)
      EMIT: begin
        out_d    = rd_nib;
        enable_d = (ridx_q == 3'd0);
        busy_d   = 1'b1;
        if (ridx_q == 3'd5) begin
          state_d = IDLE;
          ridx_d  = 3'd0;
        end else begin
          ridx_d = ridx_q + 3'd1;
        end
      end
      default: ;
    endcase
    if (done) begin
      state_d = EMIT;
      ridx_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      widx_q      <= '0;
      ridx_q      <= '0;
      slot_q      <= '0;
      outbuf_q    <= '0;
      out_q       <= '0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      corrected_q <= 1'b0;
      sync_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      ridx_q      <= ridx_d;
      slot_q      <= slot_d;
      outbuf_q    <= outbuf_d;
      out_q       <= out_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      corrected_q <= corrected_d;
      sync_err_q  <= sync_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out       = out_q;
  assign enable    = enable_q;
  assign busy      = busy_q;
  assign corrected = corrected_q;
  assign sync_err  = sync_err_q;
  assign err_count = cnt_q;
endmodule

// File: tb/tb_hamming_frame_decoder.sv
// Scoreboard bench for hamming_frame_decoder: expected nibbles/frames are queued
// as codewords are driven and popped as burst cycles appear on the output.
module tb_hamming_frame_decoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  code_in = '0;
  logic        code_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [3:0]  out, out4;
  logic        enable, busy, corrected, sync_err;
  logic        enable4, busy4, corrected4, sync_err4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;

  always #5 clk = ~clk;

  hamming_frame_decoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .frame_start(frame_start), .out(out), .enable(enable), .busy(busy),
    .corrected(corrected), .sync_err(sync_err), .err_count(err_count));

  hamming_frame_decoder #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .frame_start(frame_start), .out(out4), .enable(enable4), .busy(busy4),
    .corrected(corrected4), .sync_err(sync_err4), .err_count(err_count4));

  typedef struct { logic [3:0] nib; logic first; } exp_t;
  exp_t        exp_q[$];
  logic [23:0] frm_q[$];

  int checks = 0, fails = 0;
  int n_err = 0, corr_cnt = 0, sync_cnt = 0;
  int cyc = 0, last_en = -1, pos = -1;
  bit b2b = 0;
  logic [23:0] shift = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic b2, b4, b5, b6;
    {b2, b4, b5, b6} = d;
    return {b6, b5, b4, b4 ^ b5 ^ b6, b2, b2 ^ b5 ^ b6, b2 ^ b4 ^ b6};
  endfunction

  task automatic send(input logic [6:0] c, input logic fs);
    code_in = c; code_valid = 1'b1; frame_start = fs;
    @(posedge clk); #1;
    code_valid = 1'b0; frame_start = 1'b0;
  endtask

  // flip_mask bit i corrupts nibble i; fbit < 0 picks a random bit position
  task automatic send_frame(input logic [23:0] f, input logic [5:0] flip_mask,
                            input int fbit, input logic fs);
    logic [6:0] c;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.nib = f[23-4*i -: 4]; e.first = (i == 0);
      exp_q.push_back(e);
    end
    frm_q.push_back(f);
    for (int i = 0; i < 6; i++) begin
      c = enc(f[23-4*i -: 4]);
      if (flip_mask[i]) begin
        c[(fbit < 0) ? $urandom_range(0, 6) : fbit] ^= 1'b1;
        n_err++;
      end
      send(c, fs && (i == 0));
    end
  endtask

  task automatic drain(input string tag);
    repeat (12) @(posedge clk);
    #1;
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt16"}, err_count, n_err);
    chk({tag, "_cnt4"}, err_count4, (n_err > 15) ? 15 : n_err);
    chk({tag, "_corr"}, corr_cnt, n_err);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      pos = -1;
    end else if (busy) begin
      if (exp_q.size() == 0) chk("unexp_out", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("out", out, e.nib);
        chk("enable", enable, e.first);
      end
      if (enable) begin
        if (b2b && last_en >= 0) chk("en_space", cyc - last_en, 6);
        last_en = cyc;
        pos = 0;
      end
      if (pos >= 0) begin
        shift = {shift[19:0], out};
        if (pos == 5) begin
          if (frm_q.size() == 0) chk("frame_q", frm_q.size(), 1);
          else chk("frame", shift, frm_q.pop_front());
          pos = -1;
        end else pos++;
      end
    end else begin
      if (pos >= 0) chk("busy_gap", busy, 1);
      chk("enable_idle", enable, 0);
      pos = -1;
    end
    corr_cnt += corrected;
    sync_cnt += sync_err;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    // reset state
    #1 reset = 1'b0;
    #1;
    chk("rst_out", out, 0);       chk("rst_enable", enable, 0);
    chk("rst_busy", busy, 0);     chk("rst_corr", corrected, 0);
    chk("rst_sync", sync_err, 0); chk("rst_cnt", err_count, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // clean frame of 0x66 codewords
    send_frame(24'hBBBBBB, 6'b0, -1, 1'b1);
    drain("clean_drain");
    chk_cnt("clean");
    chk("clean_sync", sync_cnt, 0);

    // single-bit error in slot 2 (0x76)
    send_frame(24'hBBBBBB, 6'b000100, 4, 1'b1);
    drain("corr_drain");
    chk_cnt("corr");

    // back-to-back frames on continuous code_valid
    b2b = 1; last_en = -1;
    send_frame(24'h123456, 6'b0, -1, 1'b1);
    send_frame(24'h9ABCDE, 6'b0, -1, 1'b0);
    send_frame(24'hF0E1D2, 6'b0, -1, 1'b1);
    drain("b2b_drain");
    b2b = 0;

    // resync: partial frame discarded by frame_start
    s0 = sync_cnt;
    send(enc(4'h7), 1'b1);
    send(enc(4'h8), 1'b0);
    send(enc(4'h9), 1'b0);
    send_frame(24'hA5C30F, 6'b0, -1, 1'b1);
    drain("resync_drain");
    chk("resync_sync", sync_cnt - s0, 1);

    // 20 erroneous codewords: 4-bit counter saturates at 15
    send_frame(24'h1E2D3C, 6'h3F, -1, 1'b1);
    send_frame(24'h4B5A69, 6'h3F, -1, 1'b0);
    send_frame(24'h778899, 6'h3F, -1, 1'b0);
    send_frame(24'hCAFE12, 6'b000011, -1, 1'b0);
    drain("sat_drain");
    chk_cnt("sat");

    // async reset on burst cycle 3
    send_frame(24'h314159, 6'b0, -1, 1'b1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete(); frm_q.delete(); n_err = 0; corr_cnt = 0;
    #1;
    chk("mid_out", out, 0);       chk("mid_enable", enable, 0);
    chk("mid_busy", busy, 0);     chk("mid_corr", corrected, 0);
    chk("mid_sync", sync_err, 0); chk("mid_cnt16", err_count, 0);
    chk("mid_cnt4", err_count4, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    send_frame(24'h271828, 6'b100000, -1, 1'b1);
    drain("post_rst_drain");
    chk_cnt("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/hamming_frame_decoder.md
# hamming_frame_decoder

Receive-side Hamming(7,4) decoder that sits directly upstream of the 24-bit nibble reassembly stage. It accepts 7-bit codewords, corrects any single-bit error, and collects six corrected nibbles into one frame. It then replays the frame as a 6-cycle nibble burst (`enable` high on the first nibble only), which is the input protocol the reassembly stage requires. It also keeps a saturating count of corrected codewords for link-quality monitoring.

## Interface
- `CNT_W`, default 16: width of the corrected-codeword counter.
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `code_in`, input, 7: codeword; `code_in[i]` is Hamming position i+1 (p1,p2,d1,p3,d2,d3,d4 = bits 0..6).
- `code_valid`, input, 1: `code_in` is valid this cycle; at most one codeword per cycle.
- `frame_start`, input, 1: qualified by `code_valid`; this codeword is nibble 0 of a frame.
- `out`, output, 4: decoded nibble to the reassembly stage.
- `enable`, output, 1: 1-cycle strobe marking nibble 0 (bits 23:20) of a burst.
- `busy`, output, 1: a burst is in progress (high on all 6 burst cycles).
- `corrected`, output, 1: 1-cycle pulse, registered, one cycle after a codeword needing correction was accepted.
- `sync_err`, output, 1: 1-cycle pulse when `frame_start` arrives with a partial frame pending.
- `err_count`, output, `CNT_W`: saturating count of corrected codewords.

## Operation
- Decode is combinational on `code_in`:
  - s1 = b0^b2^b4^b6, s2 = b1^b2^b5^b6, s3 = b3^b4^b5^b6.
  - Syndrome S = {s3,s2,s1}. S≠0 flips bit S-1; then nibble = {b2,b4,b5,b6}, d1 as MSB.
  - Double errors are not detected; they decode as a (wrong) single-bit correction.
- Assembly buffer holds six 4-bit slots and a write index `widx` (0..5).
- On `code_valid`:
  - Slot[widx] ← corrected nibble.
  - If `frame_start`, the nibble goes to slot 0 and `widx` ← 1.
  - Otherwise `widx` increments.
  - When the nibble is written to slot 5, the frame is complete and `widx` ← 0.
- Sync error: if `frame_start` arrives with `widx`≠0, the partial frame is discarded and `sync_err` pulses. `frame_start` is not required; without it, frames are taken as consecutive groups of six.
- Frame complete: all six nibbles are copied into the output buffer, and the burst FSM moves to EMIT with `ridx` = 0.
- Burst FSM:
  - IDLE: `out` holds its last value, `enable` = 0, `busy` = 0.
  - EMIT: `out` ← outbuf[ridx]; `enable` = 1 only when `ridx` = 0; `busy` = 1; `ridx` increments each cycle. After `ridx` = 5 the FSM returns to IDLE, unless a new frame completed on that same cycle, in which case it restarts at `ridx` = 0.
- Overlap: a new frame can complete no sooner than 6 cycles after the previous one. The output buffer is therefore never overwritten mid-burst, and bursts may run back-to-back, with `enable` spaced exactly 6 cycles apart.
- Counter: `err_count` increments on each accepted codeword with S≠0 and saturates at all-ones.

## Timing
- Reset (async, `reset` = 0) clears all outputs immediately:
  - `out` = 0, `enable` = 0, `busy` = 0, `corrected` = 0, `sync_err` = 0, `err_count` = 0.
  - `widx` = 0, `ridx` = 0, FSM = IDLE, buffers = 0.
- Reset release is sampled at the next rising edge.
- Latency: 6th codeword sampled at edge N → `out` = nibble 0 and `enable` = 1 after edge N+1. Nibbles 1..5 follow after edges N+2..N+6, one per cycle, with no gaps. `busy` is high after edges N+1..N+6.
- Gaps in `code_valid` during assembly are allowed; bursts are never gapped.
- Reset mid-burst aborts the burst; the partial frame is lost and `enable` is never re-issued for it.
- `corrected` and `sync_err` assert the cycle after the triggering codeword is sampled.

## Test plan
- Clean frame: six codewords 0x66 (data 0xB) with `frame_start` on the first → one burst of six `out` = 0xB, `enable` only on the first cycle; `err_count` = 0; reassembly stage yields 0xBBBBBB.
- Single-bit correction: codeword 0x76 (0x66 with b4 flipped) in slot 2 → slot 2 still decodes to 0xB; `corrected` pulses once; `err_count` = 1.
- Back-to-back frames on continuous `code_valid` → `enable` pulses exactly 6 cycles apart; `busy` stays high continuously; every nibble is in order.
- Resync: three codewords, then `frame_start` with six new codewords → `sync_err` pulses once; only the new frame is emitted.
- Saturation with `CNT_W` = 4: 20 erroneous codewords → `err_count` stops at 15.
- Async reset asserted on burst cycle 3 → all outputs drop to 0 without waiting for a clock edge; after release, the next complete frame is emitted normally.
